pci_target: RTL
===============

// Module: pci_target
// PURPOSE
//  Synthesizable PCI memory-space target (responder): claims Memory Read/Write bursts
//  from the bus initiator and serves them from a small internal word array. Completes
//  the initiator/target pair on the shared FRAME_/IRDY_/TRDY_/DEVSEL_/C_BE_/AD bus.
//  Initiator drives on negedge clk. This block samples and updates only on posedge clk.
// PARAMETERS
//  BASE_ADDR   32'h0000_1200  byte base of decoded window (4*MEM_DEPTH aligned)
//  MEM_DEPTH   8              number of 32-bit words; window = BASE_ADDR..+4*MEM_DEPTH-1
//  DEVSEL_DLY  0              extra clocks before DEVSEL_ (0=fast, 1=medium)
//  INIT_WAIT   1              target wait states before first TRDY_ of a burst (0..3)
// PORTS
//  clk       in     1   bus clock, all state on posedge
//  reset_    in     1   synchronous, active-low reset
//  FRAME_    in     1   initiator cycle frame, active-low
//  IRDY_     in     1   initiator ready, active-low
//  C_BE_     in     4   command (addr phase) / byte enables, active-low (data phase)
//  AD        inout  32  multiplexed addr/data; driven only during read data phases
//  TRDY_     out    1   target ready, active-low
//  DEVSEL_   out    1   device select, active-low
//  STOP_     out    1   target disconnect request, active-low
// BEHAVIOUR
//  Reset: TRDY_=DEVSEL_=STOP_=1, AD released (Z), FSM=IDLE. Memory contents not reset.
//  Reset asserted mid-burst: same values at the next posedge; no partial write is completed.
//  Address phase: FRAME_ sampled 0 while previous sample 1; latch AD and C_BE_.
//  Hit: C_BE_ in {4'b0110 MEM_READ, 4'b0111 MEM_WRITE} and AD in window.
//  Index: (AD-BASE_ADDR)>>2. AD[1:0] ignored.
//  Miss/other cmd: no response; IDLE until FRAME_=1 and IRDY_=1 sampled.
//  FSM: IDLE -> DECODE -> WAIT -> DATA -> TURN -> IDLE.
//  DECODE: lasts DEVSEL_DLY clocks (0 = skipped). DEVSEL_ low on the edge leaving DECODE.
//  DECODE, read: AD drive enable set one clock after address phase (turnaround).
//  WAIT: INIT_WAIT clocks, TRDY_ high, DEVSEL_ low, read data mem[idx] already on AD.
//  DATA: TRDY_ low. Transfer = TRDY_ and IRDY_ both sampled 0 at a posedge.
//  DATA, read: on transfer idx++, next word on AD the same edge. No burst wait states.
//  DATA, write: on transfer, byte lane b of mem[idx] written iff C_BE_[b]=0; idx++.
//  DATA, IRDY_=1: hold AD, TRDY_ and idx (initiator wait state).
//  End of burst: transfer with FRAME_=1 -> TURN. TRDY_=DEVSEL_=1 and AD released.
//  TURN: lasts exactly 1 clock, then IDLE.
//  Window end: presenting idx=MEM_DEPTH-1 with FRAME_ still 0 -> STOP_ low with TRDY_.
//  Window end, after that transfer: TRDY_=1. STOP_/DEVSEL_ held low until FRAME_=1 sampled.
//  Window end, then TURN. Disconnect-with-data; idx never wraps.
//  Back-to-back: an address phase sampled in TURN is ignored; the initiator must idle 1 clock.
// CONFIGURATION
//  PCI_TGT_PAR_EN defined: adds port PAR (inout, 1).
//   Read: PAR = even parity of AD+C_BE_, driven the clock after each AD-driven clock.
//   Write: parity checked; mismatch pulses output PERR_ low for 1 clock, 2 clocks after the data.
//  PCI_TGT_PAR_EN undefined: no PAR/PERR_ ports, no parity logic.
// STRUCTURE
//  pci_pkg: PCI_CMD_MEM_READ/PCI_CMD_MEM_WRITE localparams, tgt_state_e enum
//   (IDLE, DECODE, WAIT, DATA, TURN), shared with the initiator model.
//  Sub-module pci_tgt_mem: MEM_DEPTH x 32 array, byte-enabled sync write, async read.
//  Top: FSM, address decode, index counter, AD tri-state.
// TESTING
//  Write then read back:
//   Write 0x1200 burst 0x11111111,0x22222222 with C_BE_=0000 -> DEVSEL_ low 1 clk after addr.
//   Read 0x1200 x2 -> AD=0x11111111 then 0x22222222.
//  Byte enables: write 0xAABBCCDD at 0x1204 with C_BE_=4'b1100 to prior 0x22222222
//   -> readback 0x2222CCDD.
//  Initiator wait:
//   Read 0x1200 x3 with IRDY_ high 1 clk mid-burst -> TRDY_ stays low, AD held.
//   Read 0x1200 x3 -> 3 words in order, TRDY_ high the clock after last transfer.
//  Miss:
//   C_BE_=0110 at 0x1300 -> DEVSEL_/TRDY_ stay 1, AD stays Z for the whole cycle.
//   C_BE_=0010 (I/O read) at 0x1200 -> DEVSEL_/TRDY_ stay 1, AD stays Z for the whole cycle.
//  Window end: read 0x1218 with FRAME_ held -> word 6, then word 7 with STOP_=0.
//   Then TRDY_=1, STOP_ released 1 clk after FRAME_=1.
//  Reset mid-burst: reset_=0 during write DATA -> all outputs 1, AD=Z next edge.
//   After reset, a read at 0x1200 -> DEVSEL_ asserts normally (burst restarts cleanly).

Source files
------------

// File: rtl/pci_pkg.sv
// pci_pkg: definitions shared by the PCI memory target and the initiator model.
//   PCI_CMD_MEM_READ / PCI_CMD_MEM_WRITE : C_BE_ command codes decoded in the address phase
//   tgt_state_e                          : target FSM states
package pci_pkg;

    localparam logic [3:0] PCI_CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] PCI_CMD_MEM_WRITE = 4'b0111;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WAIT,
        DATA,
        TURN
    } tgt_state_e;

endpackage

// File: rtl/pci_if.sv
// pci_if: PCI control/handshake signals shared by initiator and target.
//   FRAME_, IRDY_ : initiator framing and ready, active-low
//   C_BE_         : command (address phase) / byte enables (data phase), active-low
//   TRDY_, DEVSEL_, STOP_ : target ready, device select, disconnect, active-low
// The multiplexed AD bus is a tri-state net and is carried as a separate inout port.
interface pci_if;

    logic       FRAME_;
    logic       IRDY_;
    logic [3:0] C_BE_;
    logic       TRDY_;
    logic       DEVSEL_;
    logic       STOP_;

    modport master (
        output FRAME_, IRDY_, C_BE_,
        input  TRDY_, DEVSEL_, STOP_
    );

    modport slave (
        input  FRAME_, IRDY_, C_BE_,
        output TRDY_, DEVSEL_, STOP_
    );

endinterface

// File: rtl/pci_tgt_mem.sv
// pci_tgt_mem: DEPTH x 32-bit word store for the PCI target.
//   clk   : write clock
//   we    : write strobe
//   addr  : word index, shared by read and write
//   be    : byte enables, active-high, one per byte lane
//   wdata : write data
//   rdata : asynchronous read of mem[addr]
// Contents are never reset.
module pci_tgt_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/pci_target.sv
// pci_target: PCI memory-space target serving Memory Read/Write bursts from a
// MEM_DEPTH-word array mapped at BASE_ADDR. Samples and updates on posedge clk only.
//   clk     : bus clock
//   reset_  : synchronous, active-low reset
//   bus     : pci_if.slave (FRAME_, IRDY_, C_BE_ in; TRDY_, DEVSEL_, STOP_ out)
//   AD      : multiplexed address/data, driven only during read data phases
// Optional feature, macro PCI_TGT_PAR_EN:
//   PAR     : inout, even parity over AD and C_BE_, driven the clock after AD is driven
//   PERR_   : output, low for one clock when write-data parity mismatches
module pci_target
    import pci_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1200,
    parameter int          MEM_DEPTH  = 8,
    parameter int          DEVSEL_DLY = 0,
    parameter int          INIT_WAIT  = 1
) (
    input  logic       clk,
    input  logic       reset_,
    pci_if.slave       bus,
    inout  wire [31:0] AD
`ifdef PCI_TGT_PAR_EN
    ,
    inout  wire        PAR,
    output logic       PERR_
`endif
);

    localparam int            AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [AW-1:0] LAST    = AW'(MEM_DEPTH - 1);
    localparam logic [31:0]   WIN_END = BASE_ADDR + 32'(4 * MEM_DEPTH);

    tgt_state_e    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          rd_q, rd_d;
    logic          disc_q, disc_d;
    logic          miss_q, miss_d;
    logic          frame_q;
    logic          trdy_q, trdy_d;
    logic          devsel_q, devsel_d;
    logic          stop_q, stop_d;
    logic          ad_oe, ad_oe_d;
    logic          we;
    logic          claim;
    logic          addr_phase;
    logic          addr_hit;
    logic          cmd_ok;
    logic [AW-1:0] hit_idx;
    logic [31:0]   rdata;

    // A new address phase is a FRAME_ falling edge while idle; a missed burst
    // blocks detection until the bus is seen fully idle.
    assign addr_phase = (state_q == IDLE) && frame_q && !bus.FRAME_ && !miss_q;
    assign addr_hit   = (AD >= BASE_ADDR) && (AD < WIN_END);
    assign cmd_ok     = (bus.C_BE_ == PCI_CMD_MEM_READ) || (bus.C_BE_ == PCI_CMD_MEM_WRITE);
    assign hit_idx    = AW'((AD - BASE_ADDR) >> 2);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rd_d     = rd_q;
        disc_d   = disc_q;
        miss_d   = miss_q;
        trdy_d   = 1'b1;
        devsel_d = 1'b1;
        stop_d   = 1'b1;
        ad_oe_d  = 1'b0;
        we       = 1'b0;
        claim    = 1'b0;
        if (miss_q && bus.FRAME_ && bus.IRDY_) begin
            miss_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (addr_phase) begin
                    if (addr_hit && cmd_ok) begin
                        idx_d = hit_idx;
                        rd_d  = (bus.C_BE_ == PCI_CMD_MEM_READ);
                        if (DEVSEL_DLY != 0) begin
                            state_d = DECODE;
                            cnt_d   = 2'(DEVSEL_DLY - 1);
                        end else begin
                            claim = 1'b1;
                        end
                    end else begin
                        miss_d = 1'b1;
                    end
                end
            end
            DECODE: begin
                // First clock after the address phase is the AD turnaround.
                ad_oe_d = rd_q;
                if (cnt_q == 2'd0) begin
                    claim = 1'b1;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            WAIT: begin
                devsel_d = 1'b0;
                ad_oe_d  = rd_q;
                if (cnt_q == 2'd0) begin
                    state_d = DATA;
                    trdy_d  = 1'b0;
                    stop_d  = !((idx_q == LAST) && !bus.FRAME_);
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DATA: begin
                if (disc_q) begin
                    // Last word already moved; keep signalling disconnect.
                    if (bus.FRAME_) begin
                        state_d = TURN;
                        disc_d  = 1'b0;
                    end else begin
                        devsel_d = 1'b0;
                        stop_d   = 1'b0;
                    end
                end else if (!bus.IRDY_) begin
                    we = !rd_q;
                    if (bus.FRAME_) begin
                        state_d = TURN;
                    end else if (idx_q == LAST) begin
                        disc_d   = 1'b1;
                        devsel_d = 1'b0;
                        stop_d   = 1'b0;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        devsel_d = 1'b0;
                        trdy_d   = 1'b0;
                        ad_oe_d  = rd_q;
                        stop_d   = !((idx_q + 1'b1) == LAST);
                    end
                end else begin
                    devsel_d = 1'b0;
                    trdy_d   = 1'b0;
                    ad_oe_d  = rd_q;
                    stop_d   = stop_q;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Leaving decode: claim the cycle, then wait states or straight to data.
        if (claim) begin
            devsel_d = 1'b0;
            if (INIT_WAIT != 0) begin
                state_d = WAIT;
                cnt_d   = 2'(INIT_WAIT - 1);
            end else begin
                state_d = DATA;
                trdy_d  = 1'b0;
                stop_d  = !((idx_d == LAST) && !bus.FRAME_);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            idx_q    <= '0;
            rd_q     <= 1'b0;
            disc_q   <= 1'b0;
            miss_q   <= 1'b0;
            frame_q  <= 1'b1;
            trdy_q   <= 1'b1;
            devsel_q <= 1'b1;
            stop_q   <= 1'b1;
            ad_oe    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rd_q     <= rd_d;
            disc_q   <= disc_d;
            miss_q   <= miss_d;
            frame_q  <= bus.FRAME_;
            trdy_q   <= trdy_d;
            devsel_q <= devsel_d;
            stop_q   <= stop_d;
            ad_oe    <= ad_oe_d;
        end
    end

    // Write strobe is gated by reset so a burst cut by reset leaves memory untouched.
    pci_tgt_mem #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we && reset_),
        .addr  (idx_q),
        .be    (~bus.C_BE_),
        .wdata (AD),
        .rdata (rdata)
    );

    assign AD          = ad_oe ? rdata : 32'bz;
    assign bus.TRDY_   = trdy_q;
    assign bus.DEVSEL_ = devsel_q;
    assign bus.STOP_   = stop_q;

`ifdef PCI_TGT_PAR_EN
    logic par_q, par_oe;
    logic chk_p0, exp_p0;
    logic err_p1;
    logic perr_q;

    // Stage p0: capture parity of the current AD/C_BE_ and mark write transfers.
    always_ff @(posedge clk) begin
        par_q  <= ^{rdata, bus.C_BE_};
        exp_p0 <= ^{AD, bus.C_BE_};
    end

    // Stage p1: compare against PAR one clock later; stage p2: drive PERR_.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            par_oe <= 1'b0;
            chk_p0 <= 1'b0;
            err_p1 <= 1'b0;
            perr_q <= 1'b1;
        end else begin
            par_oe <= ad_oe;
            chk_p0 <= we;
            err_p1 <= chk_p0 && (PAR != exp_p0);
            perr_q <= !err_p1;
        end
    end

    assign PAR   = par_oe ? par_q : 1'bz;
    assign PERR_ = perr_q;
`endif

endmodule
